bcd_count_arb: RTL and testbench

BCD_COUNT_ARB -- requirements
Module: bcd_count_arb

---
 rtl/bcd_count_arb.sv | 134 +++++++++++++
 tb/tb_bcd_count_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_arb.sv
// Round-robin arbiter that lends one external BCD counter to two requesters,
// loads a clamped target, waits for the digits to match, and guards with a watchdog.
//
// state | meaning
// IDLE  | no owner, counter held clear, arbitrating
// LOAD  | owner granted, counter held clear for LOAD_CYCLES cycles
// COUNT | counter running, comparing digits, watchdog counting
// DONE  | one-cycle completion pulse to the owner
module bcd_count_arb #(
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [6:0] max_a,
  input  logic [6:0] max_b,
  input  logic [3:0] cnt_digit_1,
  input  logic [3:0] cnt_digit_2,
  output logic       cnt_run,
  output logic [6:0] cnt_max,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t     state;
  logic [3:0] load_tmr;
  logic [7:0] wdog;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       last_b;

  logic       pick_b;
  logic [6:0] sel_max;
  logic [6:0] clamped;
  logic       own_req;
  logic [7:0] wdog_nxt;
  logic       match;
  logic       rel;

  // last_b=1 means B was served last, so A wins a tie
  assign pick_b   = req_b && (!req_a || !last_b);
  assign sel_max  = pick_b ? max_b : max_a;
  assign clamped  = (sel_max > 7'd99) ? 7'd99 : sel_max;
  assign own_req  = gnt_b ? req_b : req_a;
  assign wdog_nxt = wdog + 8'd1;
  assign match    = (cnt_digit_2 == tens) && (cnt_digit_1 == ones);

  always_comb begin
    rel = 1'b0;
    case (state)
      LOAD:    rel = !own_req;
      COUNT:   rel = !own_req || (!match && (wdog_nxt == 8'(TIMEOUT)));
      DONE:    rel = 1'b1;
      default: rel = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt_run  <= 1'b0;
      cnt_max  <= 7'd0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      wdog     <= 8'd0;
      load_tmr <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      last_b   <= 1'b1;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      err    <= 1'b0;
      if (rel) begin
        state   <= IDLE;
        gnt_a   <= 1'b0;
        gnt_b   <= 1'b0;
        busy    <= 1'b0;
        cnt_run <= 1'b0;
        wdog    <= 8'd0;
        last_b  <= gnt_b;
        err     <= (state == COUNT) && own_req;
      end else begin
        case (state)
          IDLE: begin
            if (req_a || req_b) begin
              state    <= LOAD;
              gnt_a    <= !pick_b;
              gnt_b    <= pick_b;
              busy     <= 1'b1;
              cnt_run  <= 1'b0;
              cnt_max  <= clamped;
              tens     <= 4'(clamped / 7'd10);
              ones     <= 4'(clamped % 7'd10);
              load_tmr <= 4'(LOAD_CYCLES - 1);
            end
          end
          LOAD: begin
            if (load_tmr == 4'd0) begin
              state   <= COUNT;
              cnt_run <= 1'b1;
              wdog    <= 8'd0;
            end else begin
              load_tmr <= load_tmr - 4'd1;
            end
          end
          COUNT: begin
            if (match) begin
              state  <= DONE;
              done_a <= gnt_a;
              done_b <= gnt_b;
            end else begin
              wdog <= wdog_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_count_arb.sv
// Bench for bcd_count_arb: external BCD counter model, cycle-level service model
// compared every cycle, directed scenarios with hand-computed expectations, random traffic.
module tb_bcd_count_arb;
  localparam int LC = 2;
  localparam int TO = 255;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [6:0] max_a = 7'd0, max_b = 7'd0;
  logic [3:0] cnt_digit_1, cnt_digit_2;
  logic       cnt_run, gnt_a, gnt_b, done_a, done_b, err, busy;
  logic [6:0] cnt_max;

  int compared = 0;
  int mismatched = 0;

  bcd_count_arb #(.LOAD_CYCLES(LC), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_a(req_a), .req_b(req_b),
    .max_a(max_a), .max_b(max_b),
    .cnt_digit_1(cnt_digit_1), .cnt_digit_2(cnt_digit_2),
    .cnt_run(cnt_run), .cnt_max(cnt_max), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .done_a(done_a), .done_b(done_b), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // external counter: cleared while cnt_run is low, counts up to cnt_max otherwise
  int cval = 0;
  bit freeze = 1'b0;
  always @(posedge CLK) begin
    if (cnt_run !== 1'b1) cval <= 0;
    else if (!freeze && cval < int'(cnt_max)) cval <= cval + 1;
  end
  assign cnt_digit_1 = 4'(cval % 10);
  assign cnt_digit_2 = 4'(cval / 10);

  // service model: owner (0 none, 1 A, 2 B) and cycles elapsed since the grant
  int m_owner = 0, m_age = 0, m_last = 2, m_target = 0, m_max = 0;
  bit m_fin = 0, m_err = 0, m_valid = 0;

  always @(posedge CLK) begin : model
    int win;
    bit own;
    if (!RST_N) begin
      m_owner = 0; m_age = 0; m_fin = 0; m_err = 0; m_last = 2; m_max = 0; m_valid = 1;
    end else if (m_valid) begin
      m_err = 0;
      if (m_owner == 0) begin
        win = 0;
        if (req_a && req_b) win = (m_last == 1) ? 2 : 1;
        else if (req_a) win = 1;
        else if (req_b) win = 2;
        if (win != 0) begin
          m_owner = win; m_age = 0; m_fin = 0;
          m_target = (win == 1) ? int'(max_a) : int'(max_b);
          if (m_target > 99) m_target = 99;
          m_max = m_target;
        end
      end else if (m_fin) begin
        m_last = m_owner; m_owner = 0; m_fin = 0;
      end else begin
        own = (m_owner == 1) ? req_a : req_b;
        if (!own) begin
          m_last = m_owner; m_owner = 0;
        end else if (m_age < LC) begin
          m_age++;
        end else if (int'(cnt_digit_1) < 10 &&
                     int'(cnt_digit_2) * 10 + int'(cnt_digit_1) == m_target) begin
          m_fin = 1;
        end else if (m_age - LC + 1 == TO) begin
          m_err = 1; m_last = m_owner; m_owner = 0;
        end else begin
          m_age++;
        end
      end
    end
  end

  always @(negedge CLK) begin : compare
    logic [13:0] act, exp;
    if (m_valid) begin
      act = {busy, gnt_a, gnt_b, done_a, done_b, err, cnt_run, cnt_max};
      exp = {m_owner != 0, m_owner == 1, m_owner == 2, m_fin && m_owner == 1,
             m_fin && m_owner == 2, m_err, m_owner != 0 && m_age >= LC, 7'(m_max)};
      compared++;
      if (act !== exp) begin
        mismatched++;
        $display("FAIL cycle_model t=%0t busy/gnt_a/gnt_b/done_a/done_b/err/run/max actual=%b required=%b",
                 $time, act, exp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_done(output int who, output int cycles);
    who = 0;
    cycles = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge CLK);
      if (done_a) begin who = 1; cycles = i; return; end
      if (done_b) begin who = 2; cycles = i; return; end
    end
  endtask

  function automatic int outs_vec();
    return int'({busy, gnt_a, gnt_b, done_a, done_b, err, cnt_run, cnt_max});
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", outs_vec(), 0);
    RST_N = 1'b1;
  endtask

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    int who, cyc, n_run, seen_done;
    @(negedge CLK);
    do_reset();

    // single request, target 73
    req_a = 1'b1; max_a = 7'd73;
    @(negedge CLK);
    check("single_gnt_busy", {gnt_a, gnt_b, busy}, 3'b101);
    check("single_cnt_max", int'(cnt_max), 73);
    check("single_load1_run", int'(cnt_run), 0);
    @(negedge CLK);
    check("single_load2_run", int'(cnt_run), 0);
    @(negedge CLK);
    check("single_count_run", int'(cnt_run), 1);
    wait_done(who, cyc);
    check("single_done_who", who, 1);
    check("single_done_cycle", cyc, 74);
    check("single_done_digits", int'({cnt_digit_2, cnt_digit_1}), 8'h73);
    req_a = 1'b0;
    @(negedge CLK);
    check("single_done_once", int'(done_a), 0);

    // simultaneous requests after reset: A, B, then A, B again
    do_reset();
    req_a = 1'b1; max_a = 7'd5; req_b = 1'b1; max_b = 7'd12;
    wait_done(who, cyc); check("rr_first", who, 1); req_a = 1'b0;
    wait_done(who, cyc); check("rr_second", who, 2); req_b = 1'b0;
    @(negedge CLK);
    req_a = 1'b1; req_b = 1'b1;
    wait_done(who, cyc); check("rr_third", who, 1); req_a = 1'b0;
    wait_done(who, cyc); check("rr_fourth", who, 2); req_b = 1'b0;
    @(negedge CLK);

    // clamp 118 -> 99
    req_b = 1'b1; max_b = 7'd118;
    @(negedge CLK);
    check("clamp_cnt_max", int'(cnt_max), 99);
    wait_done(who, cyc);
    check("clamp_done_who", who, 2);
    check("clamp_done_digits", int'({cnt_digit_2, cnt_digit_1}), 8'h99);
    req_b = 1'b0;
    @(negedge CLK);

    // zero target completes on the first COUNT cycle
    req_a = 1'b1; max_a = 7'd0;
    wait_done(who, cyc);
    check("zero_done_who", who, 1);
    check("zero_done_cycle", cyc, 1 + LC + 1);
    req_a = 1'b0;
    @(negedge CLK);

    // max change after grant is ignored
    req_a = 1'b1; max_a = 7'd15;
    repeat (4) @(negedge CLK);
    max_a = 7'd40;
    wait_done(who, cyc);
    check("change_done_who", who, 1);
    check("change_cnt_max", int'(cnt_max), 15);
    check("change_done_digits", int'({cnt_digit_2, cnt_digit_1}), 8'h15);
    req_a = 1'b0;
    @(negedge CLK);

    // withdrawal in COUNT
    req_a = 1'b1; max_a = 7'd50;
    repeat (6) @(negedge CLK);
    req_a = 1'b0;
    seen_done = 0;
    @(negedge CLK);
    check("withdraw_idle", int'({busy, gnt_a}), 0);
    for (int i = 0; i < 4; i++) begin
      if (done_a || err) seen_done++;
      @(negedge CLK);
    end
    check("withdraw_no_done", seen_done, 0);

    // watchdog with a frozen counter
    freeze = 1'b1;
    req_a = 1'b1; max_a = 7'd20;
    n_run = 0; seen_done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (err) break;
      if (cnt_run) n_run++;
      if (done_a) seen_done++;
    end
    check("timeout_err", int'(err), 1);
    check("timeout_count_cycles", n_run, 255);
    check("timeout_no_done", seen_done + int'(done_a), 0);
    check("timeout_gnt_low", int'(gnt_a), 0);
    req_a = 1'b0; freeze = 1'b0;
    @(negedge CLK);

    // reset in the middle of COUNT, then B granted
    req_a = 1'b1; max_a = 7'd60;
    repeat (10) @(negedge CLK);
    RST_N = 1'b0; req_a = 1'b0;
    @(negedge CLK);
    check("midreset_outputs", outs_vec(), 0);
    RST_N = 1'b1; req_b = 1'b1; max_b = 7'd30;
    @(negedge CLK);
    check("midreset_gnt_b", int'({gnt_a, gnt_b}), 1);
    req_b = 1'b0;
    repeat (2) @(negedge CLK);

    // random traffic
    for (int c = 0; c < 7000; c++) begin
      RST_N = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 63) == 0) freeze = ~freeze;
      if ($urandom_range(0, 7) == 0) max_a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) max_b = 7'($urandom_range(0, 127));
      if (!req_a) req_a = ($urandom_range(0, 9) == 0);
      else if (done_a) req_a = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 149) == 0) req_a = 1'b0;
      if (!req_b) req_b = ($urandom_range(0, 9) == 0);
      else if (done_b) req_b = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 149) == 0) req_b = 1'b0;
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
